// File: rtl/draw_cmd_dispatch.sv
// draw_cmd_dispatch
//   Pops one command at a time from the command FIFO, decodes its 4-bit
//   opcode and starts the matching drawing engine with a one-cycle pulse.
//   The next pop waits until that engine reports done, or until the
//   watchdog gives up on it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enb                 permits new FIFO pops
//   ff_empty            FIFO empty flag
//   ff_rden             FIFO pop strobe (one cycle per command)
//   ff_rdat, ff_rvld    FIFO read data and its valid qualifier
//   cmd_payload         command bits below the opcode, held until the next capture
//   pixel_vld, rect_vld, rect_px_vld, char_px_vld       engine start pulses
//   pixel_done, rect_done, rect_px_done, char_px_done   engine completion
//   busy                dispatcher not idle
//   abort               one-cycle pulse when the watchdog expires
//   err_opcode          sticky: illegal opcode seen
//   err_timeout         sticky: watchdog fired
//   err_clr             clears both sticky errors (a same-cycle set wins)
//   cmd_cnt             completed-command count, wraps

module draw_cmd_dispatch #(
    parameter int FF_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 1048575,
    parameter int TO_CNT_WIDTH   = 20,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enb,
    input  logic                     ff_empty,
    output logic                     ff_rden,
    input  logic [FF_DATA_WIDTH-1:0] ff_rdat,
    input  logic                     ff_rvld,
    output logic [FF_DATA_WIDTH-5:0] cmd_payload,
    output logic                     pixel_vld,
    output logic                     rect_vld,
    output logic                     rect_px_vld,
    output logic                     char_px_vld,
    input  logic                     pixel_done,
    input  logic                     rect_done,
    input  logic                     rect_px_done,
    input  logic                     char_px_done,
    output logic                     busy,
    output logic                     abort,
    output logic                     err_opcode,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic [CNT_WIDTH-1:0]     cmd_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT     = 2'd1;
    localparam logic [1:0] S_DISPATCH = 2'd2;
    localparam logic [1:0] S_BUSY     = 2'd3;

    localparam logic [3:0] OP_PIXEL   = 4'h0;
    localparam logic [3:0] OP_RECT    = 4'h1;
    localparam logic [3:0] OP_RECT_PX = 4'h9;
    localparam logic [3:0] OP_CHAR_PX = 4'hA;

    localparam logic [TO_CNT_WIDTH-1:0] TIMEOUT_VAL = TO_CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]               state, state_next;
    logic [FF_DATA_WIDTH-1:0] cmd_reg;
    logic [TO_CNT_WIDTH-1:0]  wd, wd_next, wd_inc;
    logic [3:0]               rdat_op, cmd_op;
    logic                     cmd_legal, cmd_half, sel_done;
    logic                     pop, capture, cnt_inc, set_err_op, set_err_to;

    assign rdat_op     = ff_rdat[FF_DATA_WIDTH-1 -: 4];
    assign cmd_op      = cmd_reg[FF_DATA_WIDTH-1 -: 4];
    assign cmd_payload = cmd_reg[FF_DATA_WIDTH-5:0];
    assign wd_inc      = wd + TO_CNT_WIDTH'(1);

    // Only the engine selected by the held opcode may complete the command.
    always_comb begin
        cmd_legal = 1'b1;
        sel_done  = 1'b0;
        case (cmd_op)
            OP_PIXEL:   sel_done = pixel_done;
            OP_RECT:    sel_done = rect_done;
            OP_RECT_PX: sel_done = rect_px_done;
            OP_CHAR_PX: sel_done = char_px_done;
            default:    cmd_legal = 1'b0;
        endcase
    end

    // Half-mode engines never report done; the command completes at issue.
    assign cmd_half = ((cmd_op == OP_RECT_PX) || (cmd_op == OP_CHAR_PX)) && !cmd_reg[0];

    always_comb begin
        state_next = state;
        wd_next    = wd;
        pop        = 1'b0;
        capture    = 1'b0;
        cnt_inc    = 1'b0;
        set_err_op = 1'b0;
        set_err_to = 1'b0;
        case (state)
            S_IDLE: begin
                if (enb && !ff_empty) begin
                    pop        = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ff_rvld) begin
                    capture    = 1'b1;
                    state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (!cmd_legal) begin
                    set_err_op = 1'b1;
                    state_next = S_IDLE;
                end else if (cmd_half) begin
                    cnt_inc    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wd_next    = '0;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // Comparing the incremented count bounds BUSY to exactly
                // TIMEOUT_CYCLES cycles; a done in the final cycle still wins.
                if (sel_done) begin
                    cnt_inc    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wd_next = wd_inc;
                    if (wd_inc == TIMEOUT_VAL) begin
                        set_err_to = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Start pulses are decoded from the incoming word so they are registered
    // alongside the capture and appear exactly during DISPATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wd          <= '0;
            cmd_reg     <= '0;
            ff_rden     <= 1'b0;
            pixel_vld   <= 1'b0;
            rect_vld    <= 1'b0;
            rect_px_vld <= 1'b0;
            char_px_vld <= 1'b0;
            busy        <= 1'b0;
            abort       <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            cmd_cnt     <= '0;
        end else begin
            state       <= state_next;
            wd          <= wd_next;
            if (capture) begin
                cmd_reg <= ff_rdat;
            end
            ff_rden     <= pop;
            pixel_vld   <= capture && (rdat_op == OP_PIXEL);
            rect_vld    <= capture && (rdat_op == OP_RECT);
            rect_px_vld <= capture && (rdat_op == OP_RECT_PX);
            char_px_vld <= capture && (rdat_op == OP_CHAR_PX);
            busy        <= (state_next != S_IDLE);
            abort       <= set_err_to;
            err_opcode  <= set_err_op || (err_opcode && !err_clr);
            err_timeout <= set_err_to || (err_timeout && !err_clr);
            if (cnt_inc) begin
                cmd_cnt <= cmd_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_draw_cmd_dispatch.sv
// Directed bench for draw_cmd_dispatch with a 1-cycle-latency FIFO model
// and a shortened watchdog (15 BUSY cycles).

module tb_draw_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enb;
    logic        ff_empty;
    logic        ff_rden;
    logic [31:0] ff_rdat;
    logic        ff_rvld;
    logic [27:0] cmd_payload;
    logic        pixel_vld, rect_vld, rect_px_vld, char_px_vld;
    logic        pixel_done, rect_done, rect_px_done, char_px_done;
    logic        busy, abort, err_opcode, err_timeout, err_clr;
    logic [15:0] cmd_cnt;

    int errors = 0;
    int checks = 0;
    int n_rden, n_pix, n_rect, n_rpx, n_chr, n_abort;
    logic        rden_seen;
    logic [31:0] fifo_q[$];

    always #10 clk = ~clk;

    draw_cmd_dispatch #(
        .FF_DATA_WIDTH (32),
        .TIMEOUT_CYCLES(15),
        .TO_CNT_WIDTH  (20),
        .CNT_WIDTH     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enb         (enb),
        .ff_empty    (ff_empty),
        .ff_rden     (ff_rden),
        .ff_rdat     (ff_rdat),
        .ff_rvld     (ff_rvld),
        .cmd_payload (cmd_payload),
        .pixel_vld   (pixel_vld),
        .rect_vld    (rect_vld),
        .rect_px_vld (rect_px_vld),
        .char_px_vld (char_px_vld),
        .pixel_done  (pixel_done),
        .rect_done   (rect_done),
        .rect_px_done(rect_px_done),
        .char_px_done(char_px_done),
        .busy        (busy),
        .abort       (abort),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .cmd_cnt     (cmd_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_rden = 0; n_pix = 0; n_rect = 0; n_rpx = 0; n_chr = 0; n_abort = 0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        ff_empty = 1'b0;
    endtask

    // Advance one clock; sample just after the edge, then update the FIFO model.
    task automatic tick();
        @(posedge clk);
        #1;
        n_rden  += int'(ff_rden);
        n_pix   += int'(pixel_vld);
        n_rect  += int'(rect_vld);
        n_rpx   += int'(rect_px_vld);
        n_chr   += int'(char_px_vld);
        n_abort += int'(abort);
        ff_rvld = 1'b0;
        if (rden_seen && fifo_q.size() > 0) begin
            ff_rdat = fifo_q.pop_front();
            ff_rvld = 1'b1;
        end
        rden_seen = ff_rden;
        ff_empty  = (fifo_q.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {ff_rden, pixel_vld, rect_vld, rect_px_vld, char_px_vld,
                    busy, abort, err_opcode, err_timeout, cmd_payload, cmd_cnt}, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; enb = 1'b0; ff_empty = 1'b1; ff_rdat = '0; ff_rvld = 1'b0;
        pixel_done = 1'b0; rect_done = 1'b0; rect_px_done = 1'b0; char_px_done = 1'b0;
        err_clr = 1'b0; rden_seen = 1'b0;
        clear_counts();

        // Reset state
        ticks(2);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        ticks(2);
        check("idle_no_busy", busy, 1'b0);

        // Single rect command, done 10 BUSY cycles later
        clear_counts();
        push(32'h152A_50AA);
        enb = 1'b1;
        tick();
        check("rect_rden_hi", ff_rden, 1'b1);
        tick();
        check("rect_rden_lo", ff_rden, 1'b0);
        tick();
        check("rect_vld_hi", rect_vld, 1'b1);
        check("rect_payload", cmd_payload, 28'h52A50AA);
        tick();
        check("rect_vld_lo", rect_vld, 1'b0);
        check("rect_busy", busy, 1'b1);
        ticks(9);
        check("rect_busy_wait", busy, 1'b1);
        check("rect_cnt_wait", cmd_cnt, 16'd0);
        rect_done = 1'b1;
        tick();
        rect_done = 1'b0;
        check("rect_done_idle", busy, 1'b0);
        check("rect_cnt", cmd_cnt, 16'd1);
        check("rect_pulses", {n_rden, n_rect}, {32'd1, 32'd1});

        // Half-mode char: completes at issue
        push(32'hA000_1234);
        ticks(3);
        check("half_chr_vld", char_px_vld, 1'b1);
        check("half_chr_payload", cmd_payload, 28'h0001234);
        tick();
        check("half_chr_idle", busy, 1'b0);
        check("half_chr_cnt", cmd_cnt, 16'd2);

        // Full-mode char: waits for char_px_done
        push(32'hA000_1235);
        ticks(3);
        check("full_chr_vld", char_px_vld, 1'b1);
        ticks(3);
        check("full_chr_busy", {busy, cmd_cnt}, {1'b1, 16'd2});
        char_px_done = 1'b1;
        tick();
        char_px_done = 1'b0;
        check("full_chr_done", {busy, cmd_cnt}, {1'b0, 16'd3});

        // Illegal opcode 0x5 then a pixel command
        clear_counts();
        push(32'h5000_0001);
        push(32'h0ABC_DEF0);
        ticks(3);
        check("illegal_no_vld", {pixel_vld, rect_vld, rect_px_vld, char_px_vld}, 4'b0000);
        tick();
        check("illegal_err", {err_opcode, busy, cmd_cnt}, {1'b1, 1'b0, 16'd3});
        ticks(3);
        check("pix_vld", pixel_vld, 1'b1);
        check("pix_payload", cmd_payload, 28'hABCDEF0);
        tick();
        check("pix_busy_err_held", {busy, err_opcode}, 2'b11);
        err_clr = 1'b1;
        pixel_done = 1'b1;
        tick();
        err_clr = 1'b0;
        pixel_done = 1'b0;
        check("err_clr_opcode", {err_opcode, busy, cmd_cnt}, {1'b0, 1'b0, 16'd4});
        check("illegal_pulses", {n_pix, n_rect + n_rpx + n_chr, n_rden}, {32'd1, 32'd0, 32'd2});

        // Watchdog expiry with err_clr in the same cycle (set wins)
        clear_counts();
        push(32'h1000_0000);
        push(32'h0000_0055);
        ticks(3);
        check("wd_rect_vld", rect_vld, 1'b1);
        tick();
        ticks(14);
        check("wd_before_expiry", {busy, n_abort}, {1'b1, 32'd0});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wd_abort", {abort, err_timeout, busy, cmd_cnt}, {1'b1, 1'b1, 1'b0, 16'd4});
        tick();
        check("wd_abort_pulse_next_pop", {abort, ff_rden}, 2'b01);
        ticks(2);
        check("wd_next_pix_vld", pixel_vld, 1'b1);
        tick();
        pixel_done = 1'b1;
        tick();
        pixel_done = 1'b0;
        check("wd_next_pix_cnt", {cmd_cnt, n_abort}, {16'd5, 32'd1});

        // Done exactly at expiry wins over abort
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_timeout", err_timeout, 1'b0);
        push(32'h1000_0001);
        ticks(4);
        ticks(14);
        check("race_still_busy", busy, 1'b1);
        rect_done = 1'b1;
        tick();
        rect_done = 1'b0;
        check("race_done_wins", {abort, err_timeout, busy, cmd_cnt}, {1'b0, 1'b0, 1'b0, 16'd6});
        check("race_abort_count", n_abort, 32'd1);

        // Done from the wrong engine is ignored
        push(32'h1234_5678);
        ticks(4);
        pixel_done = 1'b1; rect_px_done = 1'b1; char_px_done = 1'b1;
        tick();
        pixel_done = 1'b0; rect_px_done = 1'b0; char_px_done = 1'b0;
        check("wrong_done_ignored", {busy, cmd_cnt}, {1'b1, 16'd6});
        rect_done = 1'b1;
        tick();
        rect_done = 1'b0;
        check("right_done", {busy, cmd_cnt}, {1'b0, 16'd7});

        // Four queued commands, enb toggled, reset during BUSY
        clear_counts();
        push(32'h9000_0010);
        push(32'hA000_0020);
        push(32'h0000_0030);
        push(32'h1000_0040);
        ticks(3);
        check("q_rpx_vld", rect_px_vld, 1'b1);
        tick();
        check("q_rpx_cnt", {busy, cmd_cnt}, {1'b0, 16'd8});
        enb = 1'b0;
        ticks(3);
        check("q_enb_low_blocks", {n_rden, busy}, {32'd1, 1'b0});
        enb = 1'b1;
        tick();
        check("q_enb_high_pops", ff_rden, 1'b1);
        ticks(2);
        check("q_chr_vld", char_px_vld, 1'b1);
        tick();
        check("q_chr_cnt", cmd_cnt, 16'd9);
        tick();
        check("q_pix_rden", ff_rden, 1'b1);
        enb = 1'b0;
        ticks(2);
        check("q_pix_vld_enb_low", pixel_vld, 1'b1);
        tick();
        check("q_pix_busy", busy, 1'b1);
        pixel_done = 1'b1;
        tick();
        pixel_done = 1'b0;
        check("q_pix_cnt", {busy, cmd_cnt}, {1'b0, 16'd10});
        ticks(2);
        check("q_no_pop_enb_low", n_rden, 32'd3);
        enb = 1'b1;
        ticks(3);
        check("q_rect_vld", rect_vld, 1'b1);
        tick();
        check("q_rect_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        enb = 1'b0;
        ticks(2);
        check_all_zero("reset_held_outputs");
        check("reset_no_pulses", n_rect + n_pix + n_rpx + n_chr, 32'd4);
        rst_n = 1'b1;
        ticks(3);
        check("post_reset_idle", {busy, n_rden}, {1'b0, 32'd4});
        push(32'hA000_0100);
        ticks(3);
        check("post_reset_no_pop_enb_low", {ff_rden, n_rden}, {1'b0, 32'd4});
        enb = 1'b1;
        tick();
        check("post_reset_pop", ff_rden, 1'b1);
        ticks(2);
        check("post_reset_chr_vld", char_px_vld, 1'b1);
        tick();
        check("post_reset_cnt", {busy, cmd_cnt}, {1'b0, 16'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
